// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine and related display blocks.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_INVROT = 2'd3
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: one step every div+1 enabled cycles, clearable.
module led_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] count;

  // Comparing with >= lets a lowered div fire on the very next enabled edge.
  assign step = enable && (count >= div);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count >= div) count <= '0;
      else              count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// N-LED pattern generator: rotate / bounce / fill / inverted rotate at a programmable rate.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     leds,
  output logic             tick,
  output logic             wrap
);

  localparam logic [N-1:0] BIT_LO = N'(1);
  localparam logic [N-1:0] BIT_HI = {1'b1, {(N-1){1'b0}}};

  mode_e        mode_q;
  logic         bounce_up;
  logic         step;
  logic         restart;
  logic [N-1:0] leds_nxt;
  logic         up_nxt;

  function automatic logic [N-1:0] seed_of(mode_e m, logic d);
    case (m)
      MODE_ROTATE: seed_of = (d == DIR_RIGHT) ? BIT_HI : BIT_LO;
      MODE_BOUNCE: seed_of = BIT_LO;
      MODE_FILL:   seed_of = '0;
      MODE_INVROT: seed_of = ~((d == DIR_RIGHT) ? BIT_HI : BIT_LO);
      default:     seed_of = BIT_LO;
    endcase
  endfunction

  function automatic logic [N-1:0] rotate(logic [N-1:0] v, logic d);
    rotate = (d == DIR_RIGHT) ? {v[0], v[N-1:1]} : {v[N-2:0], v[N-1]};
  endfunction

  assign restart = (mode_e'(mode) != mode_q);

  led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (restart),
    .div    (div),
    .step   (step)
  );

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    leds_nxt = leds;
    up_nxt   = bounce_up;
    case (mode_q)
      MODE_ROTATE, MODE_INVROT: leds_nxt = rotate(leds, dir);
      MODE_BOUNCE: begin
        if (bounce_up) begin
          if (leds[N-1]) begin
            leds_nxt = leds >> 1;
            up_nxt   = 1'b0;
          end else begin
            leds_nxt = leds << 1;
          end
        end else begin
          if (leds[0]) begin
            leds_nxt = leds << 1;
            up_nxt   = 1'b1;
          end else begin
            leds_nxt = leds >> 1;
          end
        end
      end
      MODE_FILL: leds_nxt = (&leds) ? '0 : {leds[N-2:0], 1'b1};
      default: ;
    endcase
  end

  // Restart takes priority over a coincident step and suppresses both strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds      <= BIT_LO;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      mode_q    <= MODE_ROTATE;
      bounce_up <= 1'b1;
    end else if (restart) begin
      leds      <= seed_of(mode_e'(mode), dir);
      tick      <= 1'b0;
      wrap      <= 1'b0;
      mode_q    <= mode_e'(mode);
      bounce_up <= 1'b1;
    end else if (step) begin
      leds      <= leds_nxt;
      tick      <= 1'b1;
      wrap      <= (leds_nxt == seed_of(mode_q, dir));
      bounce_up <= up_nxt;
    end else begin
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine with N = 8.
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic        dir;
  logic [15:0] div;
  logic [7:0]  leds;
  logic        tick;
  logic        wrap;

  int n_vec = 0;
  int n_bad = 0;

  led_pattern_engine #(.N(8), .DIV_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .mode   (mode),
    .dir    (dir),
    .div    (div),
    .leds   (leds),
    .tick   (tick),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] el, input logic et, input logic ew);
    check({tag, ".leds"}, 32'(leds), 32'(el));
    check({tag, ".tick"}, 32'(tick), 32'(et));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    logic [7:0] exp_l;
    int pos;

    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; dir = 1'b0; div = 16'd0;
    #12;
    chk3("reset", 8'h01, 1'b0, 1'b0);
    edge1();
    rst_n = 1'b1;
    enable = 1'b1;

    // 1. ROTATE left, div=0: step every cycle, wrap on 8th step
    for (int i = 1; i <= 9; i++) begin
      edge1();
      exp_l = 8'h01 << (i % 8);
      chk3($sformatf("rot%0d", i), exp_l, 1'b1, i == 8);
    end
    // leds = 02, count = 0

    // 2. ROTATE div=3, enable freeze, dir reversal
    div = 16'd3;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk3("div3_wait", 8'h02, 1'b0, 1'b0);
    end
    edge1();
    chk3("div3_step", 8'h04, 1'b1, 1'b0);
    edge1();
    edge1();                       // count now 2
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk3("frozen", 8'h04, 1'b0, 1'b0);
    end
    enable = 1'b1;
    edge1();
    chk3("resume_wait", 8'h04, 1'b0, 1'b0);
    edge1();
    chk3("resume_step", 8'h08, 1'b1, 1'b0);
    dir = 1'b1;
    for (int i = 0; i < 3; i++) edge1();
    chk3("dir_wait", 8'h08, 1'b0, 1'b0);
    edge1();
    chk3("dir_right", 8'h04, 1'b1, 1'b0);

    // 3. BOUNCE div=0, dir toggled every step
    mode = 2'd1;
    div = 16'd0;
    dir = 1'b0;
    edge1();
    chk3("bnc_restart", 8'h01, 1'b0, 1'b0);
    for (int s = 1; s <= 15; s++) begin
      dir = ~dir;
      edge1();
      pos = (s <= 7) ? s : (s <= 14 ? 14 - s : 1);
      exp_l = 8'h01 << pos;
      chk3($sformatf("bnc%0d", s), exp_l, 1'b1, s == 14);
    end

    // 4. FILL div=1
    mode = 2'd2;
    div = 16'd1;
    edge1();
    chk3("fill_restart", 8'h00, 1'b0, 1'b0);
    exp_l = 8'h00;
    for (int s = 1; s <= 9; s++) begin
      edge1();
      chk3($sformatf("fill%0d_wait", s), exp_l, 1'b0, 1'b0);
      edge1();
      exp_l = (s <= 8) ? 8'((9'd1 << s) - 9'd1) : 8'h00;
      chk3($sformatf("fill%0d", s), exp_l, 1'b1, s == 9);
    end

    // 5. ROTATE -> INVROT exactly on a due step edge
    mode = 2'd0;
    dir = 1'b0;
    div = 16'd2;
    edge1();
    chk3("rot_restart", 8'h01, 1'b0, 1'b0);
    edge1();
    edge1();                       // count = 2, step due next edge
    mode = 2'd3;
    edge1();
    chk3("inv_restart", 8'hFE, 1'b0, 1'b0);
    edge1();
    edge1();
    chk3("inv_wait", 8'hFE, 1'b0, 1'b0);
    edge1();
    chk3("inv_step", 8'hFD, 1'b1, 1'b0);

    // 6. asynchronous reset mid-BOUNCE
    mode = 2'd1;
    div = 16'd0;
    edge1();
    chk3("bnc2_restart", 8'h01, 1'b0, 1'b0);
    edge1();
    edge1();
    edge1();
    chk3("bnc2_run", 8'h08, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_rst", 8'h01, 1'b0, 1'b0);
    edge1();
    rst_n = 1'b1;
    edge1();
    chk3("post_rst_restart", 8'h01, 1'b0, 1'b0);
    edge1();
    chk3("post_rst_step", 8'h02, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised N-LED pattern generator for the board status/demo display. It drives N LEDs with one of four selectable patterns (rotate, bounce, fill, inverted rotate), stepping at a programmable rate derived from the system clock. It also provides step and pattern-wrap strobes for downstream logic. It is the multi-mode, rate-controlled generalisation of the single-hot chaser and sits directly behind the LED output pins.

## Interface
- `N`, default 8: number of LEDs; legal range N ≥ 2.
- `DIV_W`, default 16: width of the rate divider input.
- `clk` in, 1: system clock; all logic on the rising edge.
- `rst_n` in, 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `clk` upstream.
- `enable` in, 1: high = pattern advances; low = everything frozen.
- `mode` in, 2: 0 ROTATE, 1 BOUNCE, 2 FILL, 3 INVROT.
- `dir` in, 1: 0 = toward MSB (left), 1 = toward LSB (right).
- `div` in, DIV_W: step period minus one, in enabled clock cycles.
- `leds` out, N: LED drive, registered; 1 = lit.
- `tick` out, 1: registered one-cycle strobe marking a step.
- `wrap` out, 1: registered one-cycle strobe marking a return to the pattern seed.

## Operation
- **Reset values:** `leds` = 1 (bit0 lit); prescaler count = 0; `tick` = 0; `wrap` = 0; `mode_q` = ROTATE; bounce direction = up.
- **Prescaler:** the count runs only when `enable` = 1.
  - At an enabled edge with count ≥ `div`: count is set to 0 and a step occurs.
  - Otherwise count increments by 1.
  - `div` = 0 gives a step every enabled cycle.
  - Lowering `div` below the current count causes a step on the next enabled edge.
- **Restart:** triggered when `mode` ≠ `mode_q`, independent of `enable`.
  - On that edge: `leds` loads the seed, count is cleared, bounce direction is set to up, and `mode_q` takes `mode`.
  - No `tick` and no `wrap` are produced on a restart edge. Restart wins over a coincident step.
- **Seeds:** ROTATE is bit0 if `dir` = 0, else bit N-1. BOUNCE is bit0. FILL is all-zero. INVROT is ~bit0 if `dir` = 0, else ~bit N-1.
- **Step rules:**
  - ROTATE: rotate by one in `dir`. A change of `dir` takes effect at the next step with no restart.
  - INVROT: same as ROTATE with a single dark LED.
  - BOUNCE: single-hot. The lit bit moves up until bit N-1, then down until bit0, and so on. `dir` is ignored. Period is 2N-2 steps.
  - FILL: `leds` ← {`leds`[N-2:0], 1} until all ones; the next step gives all zeros. Period is N+1 steps; `dir` is ignored.
- **Strobes:** `wrap` asserts together with `tick` on the step whose new `leds` value equals the mode's seed. In ROTATE/INVROT, the seed check uses the current `dir`.
- **`enable` = 0:** `leds` and count hold; `tick` = `wrap` = 0. Restart still applies.
- **Reset mid-pattern:** immediate return to reset values. If `mode` ≠ ROTATE after release, a restart occurs on the first edge.

## Timing
- The step is decided at edge k. The new `leds` value, `tick` and `wrap` are all visible after edge k in the same cycle; no extra latency.
- With `enable` held high, steps occur every `div`+1 cycles. The first step comes `div`+1 edges after reset release or restart.
- A mode change lands on the edge after `mode` changes. The first step follows `div`+1 enabled edges later.
- No combinational path from any input to any output.

## Structure
- Package `led_pkg`: mode constants `MODE_ROTATE`, `MODE_BOUNCE`, `MODE_FILL`, `MODE_INVROT` (2-bit); dir constants `DIR_LEFT`, `DIR_RIGHT`.
- Sub-module `led_tick_gen` (parameter DIV_W; ports `clk`, `rst_n`, `enable`, `clear`, `div`, `step`): the prescaler, reusable by other display blocks.
- The top holds the pattern register, the bounce-direction flop, `mode_q`, seed/wrap compare logic and the strobe registers.

## Test plan
All scenarios use N = 8.
1. ROTATE, `dir` = 0, `div` = 0, `enable` = 1 after reset → `leds` 01, 02, 04 … 80, 01. `tick` is high every cycle; `wrap` is high only on the 8th step.
2. ROTATE, `div` = 3 → `leds` changes every 4 cycles. Dropping `enable` for 5 cycles freezes `leds` and count, and resumes with the remaining count intact. `dir` → 1 mid-run reverses at the next step.
3. BOUNCE, `div` = 0 → 01 … 80, 40 … 01; `wrap` on step 14. Toggling `dir` has no effect.
4. FILL, `div` = 1 → restart to 00, then 01, 03 … FF, 00 at 2-cycle spacing; `wrap` on the 9th step.
5. `mode` changed ROTATE → INVROT on the exact edge of a due step → `leds` = FE, `tick` = 0, count = 0. The next step gives FD after `div`+1 cycles.
6. `rst_n` asserted asynchronously between edges mid-BOUNCE → `leds` = 01, `tick` = `wrap` = 0 immediately. With `mode` = BOUNCE held, a restart occurs on the first edge after release.
